fp_mul_norm_round: RTL and testbench

//   Post-multiply normalise/round stage for the single-precision FP multiplier datapath.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_round_rne.sv | 26 ++
 rtl/fp_mul_norm_round.sv | 159 +++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, constants, flag indices and the stage-1 payload for the FP multiply normalise/round stage.
package fp_pkg;

    localparam int unsigned EXP_W      = 8;
    localparam int unsigned MAN_W      = 23;
    localparam int unsigned EXP_CALC_W = 10;
    localparam int unsigned PROD_W     = 48;
    localparam int unsigned FLAG_W     = 4;
    localparam int unsigned BIAS       = 127;
    localparam int unsigned EXP_MAX    = 255;

    localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;

    // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    // Normalised operand bundle held between the two pipeline stages
    typedef struct packed {
        logic                  sign;
        logic [EXP_CALC_W-1:0] e;       // two's complement exponent
        logic [MAN_W-1:0]      m;
        logic                  g;
        logic                  s;
        logic                  zero;
        logic                  inf;
        logic                  nan;
        logic                  invalid;
    } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a 23-bit mantissa with guard/sticky; carry-out bumps the exponent.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0]      m_i,
    input  logic                  g_i,
    input  logic                  s_i,
    input  logic [EXP_CALC_W-1:0] e_i,
    output logic [MAN_W-1:0]      m_o,
    output logic [EXP_CALC_W-1:0] e_o,
    output logic                  inexact_o
);

    logic           up;
    logic [MAN_W:0] sum;

    // Increment on guard when sticky is set or the lsb is odd (ties to even)
    always_comb begin
        up        = g_i & (s_i | m_i[0]);
        sum       = {1'b0, m_i} + (MAN_W + 1)'(up);
        m_o       = sum[MAN_W-1:0];
        e_o       = e_i + EXP_CALC_W'(sum[MAN_W]);
        inexact_o = g_i | s_i;
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage normalise (S1) and round/range/special-select (S2) pipeline with valid/ready handshake.
module fp_mul_norm_round
    import fp_pkg::*;
#(
    parameter logic [31:0] QNAN      = QNAN_CANON,
    parameter bit          FLUSH_SUB = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp_sum,
    input  logic [47:0] in_prod,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    input  logic        in_invalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    s1_t         s1_d, s1_q;
    logic        s1_v_q;
    logic        s2_adv;
    logic        s1_en;

    logic [MAN_W-1:0]      r_m;
    logic                  r_g;
    logic                  r_s;
    logic [EXP_CALC_W-1:0] r_e;
    logic [EXP_CALC_W-1:0] sh_amt;
    logic [MAN_W+1:0]      v_ext;
    logic [MAN_W+1:0]      v_sh;
    logic                  lost;

    logic [MAN_W-1:0]      m_rnd;
    logic [EXP_CALC_W-1:0] e_adj;
    logic                  rnd_inexact;

    logic [31:0]       result_d;
    logic [FLAG_W-1:0] flags_d;

    // Output register frees when empty or draining; S1 frees when empty or moving into S2
    always_comb begin
        s2_adv   = !out_valid | out_ready;
        s1_en    = !s1_v_q | s2_adv;
        in_ready = s1_en;
    end

    // S1: pick the product window by the leading bit and derive guard/sticky
    always_comb begin
        s1_d         = '0;
        s1_d.sign    = in_sign;
        s1_d.zero    = in_zero;
        s1_d.inf     = in_inf;
        s1_d.nan     = in_nan;
        s1_d.invalid = in_invalid;
        if (in_prod[47]) begin
            s1_d.m = in_prod[46:24];
            s1_d.g = in_prod[23];
            s1_d.s = |in_prod[22:0];
            s1_d.e = in_exp_sum + 10'd1;
        end else begin
            s1_d.m = in_prod[45:23];
            s1_d.g = in_prod[22];
            s1_d.s = |in_prod[21:0];
            s1_d.e = in_exp_sum;
        end
    end

    // S1 pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else if (s1_en) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // S2 pre-round: with subnormals enabled, shift tiny values right and fold lost bits into sticky
    always_comb begin
        r_m    = s1_q.m;
        r_g    = s1_q.g;
        r_s    = s1_q.s;
        r_e    = s1_q.e;
        v_ext  = {1'b1, s1_q.m, s1_q.g};
        sh_amt = '0;
        v_sh   = v_ext;
        lost   = 1'b0;
        if (!FLUSH_SUB && ($signed(s1_q.e) <= $signed(10'sd0))) begin
            sh_amt = 10'd1 - s1_q.e;
            v_sh   = v_ext >> sh_amt;
            lost   = |(v_ext & ~({(MAN_W + 2){1'b1}} << sh_amt));
            r_m    = v_sh[MAN_W:1];
            r_g    = v_sh[0];
            r_s    = s1_q.s | lost;
            r_e    = '0;
        end
    end

    fp_round_rne u_round (
        .m_i       (r_m),
        .g_i       (r_g),
        .s_i       (r_s),
        .e_i       (r_e),
        .m_o       (m_rnd),
        .e_o       (e_adj),
        .inexact_o (rnd_inexact)
    );

    // S2 result select: nan > inf > zero > overflow > flush > normal/subnormal
    always_comb begin
        result_d = '0;
        flags_d  = '0;
        if (s1_q.nan) begin
            result_d               = QNAN;
            flags_d[FLAG_INVALID]  = s1_q.invalid;
        end else if (s1_q.inf) begin
            result_d = {s1_q.sign, 8'hFF, 23'h0};
        end else if (s1_q.zero) begin
            result_d = {s1_q.sign, 31'h0};
        end else if ($signed(e_adj) >= $signed(10'(EXP_MAX))) begin
            result_d                = {s1_q.sign, 8'hFF, 23'h0};
            flags_d[FLAG_OVERFLOW]  = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end else if (FLUSH_SUB && ($signed(e_adj) <= $signed(10'sd0))) begin
            result_d                = {s1_q.sign, 31'h0};
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
            result_d                = {s1_q.sign, e_adj[EXP_W-1:0], m_rnd};
            flags_d[FLAG_INEXACT]   = rnd_inexact;
            flags_d[FLAG_UNDERFLOW] = (e_adj == '0) & rnd_inexact;
        end
    end

    // S2 output register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_v_q;
            if (s1_v_q) begin
                out_result <= result_d;
                out_flags  <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed self-checking bench for fp_mul_norm_round.
module tb_fp_mul_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp_sum;
    logic [47:0] in_prod;
    logic        in_zero;
    logic        in_inf;
    logic        in_nan;
    logic        in_invalid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_mul_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp_sum (in_exp_sum),
        .in_prod    (in_prod),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .in_nan     (in_nan),
        .in_invalid (in_invalid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic s, input logic [9:0] e, input logic [47:0] p,
                         input logic z, input logic i, input logic n, input logic inv);
        in_sign    = s;
        in_exp_sum = e;
        in_prod    = p;
        in_zero    = z;
        in_inf     = i;
        in_nan     = n;
        in_invalid = inv;
    endtask

    // One isolated transaction: accepted at the next edge, result visible two edges later
    task automatic run_vec(input string tag, input logic s, input logic [9:0] e, input logic [47:0] p,
                           input logic z, input logic i, input logic n, input logic inv,
                           input logic [31:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clk);
        apply(s, e, p, z, i, n, inv);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_result"}, out_result, exp_res);
        check_eq({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
    endtask

    initial begin
        int sent;
        int rcvd;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        apply(1'b0, 10'd0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", out_result, 32'h0);
        check_eq("rst_out_flags", 32'(out_flags), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Normal and rounding cases
        run_vec("mul_2p25",  1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 0, 32'h4010_0000, 4'h0);
        run_vec("tie_odd",   1'b0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 0, 32'h3F80_0002, 4'h1);
        run_vec("tie_even",  1'b0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 0, 32'h3F80_0000, 4'h1);
        run_vec("rnd_carry", 1'b0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 0, 32'h4000_0000, 4'h1);
        // Range boundaries
        run_vec("ovf",       1'b0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 0, 32'h7F80_0000, 4'h5);
        run_vec("ovf_carry", 1'b0, 10'd254, 48'h7FFF_FFC0_0000, 0, 0, 0, 0, 32'h7F80_0000, 4'h5);
        run_vec("max_norm",  1'b1, 10'd254, 48'h4000_0000_0000, 0, 0, 0, 0, 32'hFF00_0000, 4'h0);
        run_vec("unf",       1'b1, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 0, 32'h8000_0000, 4'h3);
        run_vec("unf_neg",   1'b0, 10'h3FF, 48'h8000_0000_0000, 0, 0, 0, 0, 32'h0000_0000, 4'h3);
        run_vec("min_norm",  1'b0, 10'd1,   48'h4000_0000_0000, 0, 0, 0, 0, 32'h0080_0000, 4'h0);
        // Specials and precedence
        run_vec("nan_inv",   1'b0, 10'd127, 48'h4000_0000_0000, 1, 1, 1, 1, 32'h7FC0_0000, 4'h8);
        run_vec("nan_inf",   1'b1, 10'd127, 48'h4000_0000_0000, 0, 1, 1, 0, 32'h7FC0_0000, 4'h0);
        run_vec("inf_neg",   1'b1, 10'd300, 48'h8000_0000_0000, 0, 1, 0, 0, 32'hFF80_0000, 4'h0);
        run_vec("zero",      1'b0, 10'd300, 48'h8000_0000_0000, 1, 0, 0, 0, 32'h0000_0000, 4'h0);
        run_vec("zero_neg",  1'b1, 10'd127, 48'h4000_0000_0000, 1, 0, 0, 0, 32'h8000_0000, 4'h0);

        // Streaming with a three-cycle downstream stall
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (sent < 5) begin
                apply(1'b0, 10'(127 + sent), 48'h4000_0000_0000, 0, 0, 0, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_hold", out_result, 32'h3F80_0000);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check_eq("stream_order", out_result, 32'h3F80_0000 + (32'(rcvd) << 23));
                rcvd++;
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
        check_eq("stream_count", 32'(rcvd), 32'd5);

        // Reset mid-stream drops both stages
        @(negedge clk);
        out_ready = 1'b1;
        apply(1'b0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 0);
        in_valid = 1'b1;
        @(negedge clk);
        apply(1'b0, 10'd128, 48'h4000_0000_0000, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("rst_no_partial", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
